// File: rtl/merge_2to1_stage.sv
// Two-input sorted-run merger: pops the smaller head of FIFO A/B and writes one ascending run downstream.
// Optional input-order checking is enabled by defining MERGE_ORDER_CHECK_EN.
module merge_2to1_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_a_item,
    input  logic                  i_a_empty,
    output logic                  o_a_read,
    input  logic [DATA_WIDTH-1:0] i_b_item,
    input  logic                  i_b_empty,
    output logic                  o_b_read,
    output logic [DATA_WIDTH-1:0] o_item,
    output logic                  o_write,
    input  logic                  i_almost_full,
    output logic [CNT_WIDTH-1:0]  o_run_count,
    output logic [CNT_WIDTH-1:0]  o_item_count,
    output logic                  o_order_err
);

    typedef enum logic [1:0] {
        ST_MERGE   = 2'd0,
        ST_DRAIN_A = 2'd1,
        ST_DRAIN_B = 2'd2
    } state_t;

    localparam logic [DATA_WIDTH-1:0] ZERO_W = {DATA_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0]  ONE_C  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t                state_q, state_d;
    logic                  a_rd_s, b_rd_s, emit_s;
    logic                  a_zero_s, b_zero_s;
    logic [DATA_WIDTH-1:0] emit_val_s;
    logic [DATA_WIDTH-1:0] item_q;
    logic                  write_q;
    logic [CNT_WIDTH-1:0]  run_cnt_q, item_cnt_q;

    assign a_zero_s = (i_a_item == ZERO_W);
    assign b_zero_s = (i_b_item == ZERO_W);
    assign emit_s   = a_rd_s | b_rd_s;

    // Next-state, pop decision and emitted value; a double pop always emits the terminator.
    always_comb begin
        state_d    = state_q;
        a_rd_s     = 1'b0;
        b_rd_s     = 1'b0;
        emit_val_s = ZERO_W;
        if (!i_rst_n || i_almost_full) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_MERGE: begin
                    if (!i_a_empty && !i_b_empty) begin
                        if (a_zero_s && b_zero_s) begin
                            a_rd_s = 1'b1;
                            b_rd_s = 1'b1;
                        end else if (a_zero_s) begin
                            b_rd_s     = 1'b1;
                            emit_val_s = i_b_item;
                            state_d    = ST_DRAIN_B;
                        end else if (b_zero_s) begin
                            a_rd_s     = 1'b1;
                            emit_val_s = i_a_item;
                            state_d    = ST_DRAIN_A;
                        end else if (i_a_item <= i_b_item) begin
                            a_rd_s     = 1'b1;
                            emit_val_s = i_a_item;
                        end else begin
                            b_rd_s     = 1'b1;
                            emit_val_s = i_b_item;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                // A's terminator waits at its head; it is popped together with B's terminator.
                ST_DRAIN_B: begin
                    if (!i_b_empty && !b_zero_s) begin
                        b_rd_s     = 1'b1;
                        emit_val_s = i_b_item;
                    end else if (!i_b_empty && !i_a_empty) begin
                        a_rd_s  = 1'b1;
                        b_rd_s  = 1'b1;
                        state_d = ST_MERGE;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_DRAIN_A: begin
                    if (!i_a_empty && !a_zero_s) begin
                        a_rd_s     = 1'b1;
                        emit_val_s = i_a_item;
                    end else if (!i_a_empty && !i_b_empty) begin
                        a_rd_s  = 1'b1;
                        b_rd_s  = 1'b1;
                        state_d = ST_MERGE;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: begin
                    state_d = ST_MERGE;
                end
            endcase
        end
    end

    // State, registered output stage and statistics counters.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_MERGE;
            item_q     <= ZERO_W;
            write_q    <= 1'b0;
            run_cnt_q  <= {CNT_WIDTH{1'b0}};
            item_cnt_q <= {CNT_WIDTH{1'b0}};
        end else begin
            state_q <= state_d;
            write_q <= emit_s;
            if (emit_s) begin
                item_q <= emit_val_s;
            end
            if (emit_s && (emit_val_s == ZERO_W)) begin
                run_cnt_q <= run_cnt_q + ONE_C;
            end
            if (emit_s && (emit_val_s != ZERO_W)) begin
                item_cnt_q <= item_cnt_q + ONE_C;
            end
        end
    end

    assign o_a_read     = a_rd_s;
    assign o_b_read     = b_rd_s;
    assign o_item       = item_q;
    assign o_write      = write_q;
    assign o_run_count  = run_cnt_q;
    assign o_item_count = item_cnt_q;

`ifdef MERGE_ORDER_CHECK_EN
    logic [DATA_WIDTH-1:0] last_a_q, last_b_q;
    logic                  order_err_q;

    // Per-input last popped value; a decreasing nonzero pop latches a sticky error.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            last_a_q    <= ZERO_W;
            last_b_q    <= ZERO_W;
            order_err_q <= 1'b0;
        end else begin
            if (a_rd_s) begin
                last_a_q <= i_a_item;
            end
            if (b_rd_s) begin
                last_b_q <= i_b_item;
            end
            if ((a_rd_s && !a_zero_s && (i_a_item < last_a_q)) ||
                (b_rd_s && !b_zero_s && (i_b_item < last_b_q))) begin
                order_err_q <= 1'b1;
            end
        end
    end

    assign o_order_err = order_err_q;
`else
    assign o_order_err = 1'b0;
`endif

endmodule

// File: doc/merge_2to1_stage.md
Name: merge_2to1_stage

Overview:
- Two-input streaming merger that consumes the heads of two upstream sorted-run FIFOs and writes one merged, ascending run into a downstream FIFO.
- Sits between FIFO pairs in the merge tree. Each leaf or internal node is one instance.
- Runs are delimited by a terminator word of value 0; data words are nonzero unsigned values.
- One merged item is emitted per cycle when not stalled.

Parameters:
- DATA_WIDTH, 32, width of items and terminator.
- CNT_WIDTH, 32, width of the run and item statistics counters.

Ports:
- i_clk  input  1  clock; all state updates on posedge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_a_item  input  DATA_WIDTH  head of FIFO A; valid when i_a_empty=0.
- i_a_empty  input  1  FIFO A empty.
- o_a_read  output  1  combinational pop of FIFO A this cycle.
- i_b_item  input  DATA_WIDTH  head of FIFO B.
- i_b_empty  input  1  FIFO B empty.
- o_b_read  output  1  combinational pop of FIFO B this cycle.
- o_item  output  DATA_WIDTH  registered merged item.
- o_write  output  1  registered write strobe to the downstream FIFO, one cycle per item.
- i_almost_full  input  1  downstream has 1 or fewer free entries.
- o_run_count  output  CNT_WIDTH  completed merged runs (terminators emitted).
- o_item_count  output  CNT_WIDTH  nonzero items emitted.
- o_order_err  output  1  sticky input-order error; see Optional Feature.

Behaviour:
- Reset (i_rst_n=0 at posedge):
  - state=MERGE.
  - o_item=0, o_write=0, o_run_count=0, o_item_count=0, o_order_err=0.
  - While i_rst_n=0, o_a_read=o_b_read=0 combinationally. A mid-run reset discards the partial run; the upstream FIFOs are not touched.
- Stall: no pop and no emit in any cycle with i_almost_full=1. o_write deasserts the next cycle.
- Latency: a pop decided in cycle t drives o_item/o_write at t+1. Sustained throughput is 1 item per cycle.
- State MERGE (needs A and B both non-empty; otherwise idle):
  - A=0, B=0: pop both, emit 0, o_run_count++, stay in MERGE.
  - A=0, B!=0: pop B, emit B, go to DRAIN_B. A's terminator stays at its head.
  - B=0, A!=0: pop A, emit A, go to DRAIN_A.
  - Both nonzero: emit min(A,B), using an unsigned compare. On a tie, pop and emit A.
- State DRAIN_B (needs only B non-empty; A head is known to be 0):
  - B!=0: pop B, emit B, stay in DRAIN_B.
  - B=0: pop A and B, emit 0, o_run_count++, go to MERGE.
- State DRAIN_A: mirror image of DRAIN_B.
- Counters: o_item_count++ on every nonzero emit. Both counters wrap modulo 2^CNT_WIDTH with no saturation.
- Read strobes: never assert a read on an empty FIFO. Never assert both reads except for the double-terminator pop.
- o_item holds its last value when o_write=0.
- Boundaries:
  - Empty/zero-length run (terminator first on both inputs): single 0 emitted.
  - Stall while in DRAIN state: state is retained.
  - i_almost_full rising in the same cycle as a pending registered write: the write completes, because almost_full reserves one slot.

Optional Feature:
- Macro: MERGE_ORDER_CHECK_EN.
- Defined:
  - Keep per-input last-popped nonzero values (last_a, last_b), cleared on a terminator pop and on reset.
  - A nonzero pop smaller than the last value of the same input sets o_order_err=1 the next cycle. It is sticky until reset.
  - Merging is unaffected.
- Undefined: o_order_err tied to 0; no comparison logic or last-value registers.

Test Plan:
- Basic merge: A=3,7,9,0 and B=2,8,0, downstream never almost full -> o_item sequence 2,3,7,8,9,0; o_run_count=1; o_item_count=5; every write one cycle after its pop.
- Tie plus empty runs:
  - A=5,0 and B=5,0 -> 5(A),5(B),0.
  - A=0 and B=0 -> single 0.
  - Result: o_run_count=2.
- Drain without the other FIFO: A=0 at head, then B supplies 4,6,0 one item every 3 cycles with A held non-empty -> 4,6,0 emitted with no dependence on A beyond its head; A popped exactly once.
- Backpressure: pulse i_almost_full high for 4 cycles mid-run with A=1,2,0 and B=3,0 -> no reads while high, output order 1,2,3,0, no item lost or duplicated.
- Reset mid-run: assert i_rst_n=0 in DRAIN_A -> next cycle o_write=0, counters 0, state MERGE, o_*_read=0 while in reset.
- MERGE_ORDER_CHECK_EN defined: A=9,4,0 and B=0 -> o_order_err=1 the cycle after 4 is popped, held until reset; undefined build -> o_order_err stays 0.
